mem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port data RAM of the NBBSOC between the NBBPU data port (requester 0) and a second bus master such as a loader/debug port (requester 1). It accepts at most one access per cycle, forwards it to the RAM and returns read data to the originating requester one cycle later. Requester 0 has fixed priority; a starvation counter guarantees requester 1 progress.

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port data RAM.
// Requester 0 has fixed priority; a starvation counter guarantees requester 1 progress.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  ram_read_enable,
    output logic                  ram_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic [15:0]           stall_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD0  = 2'd1,
        S_RD1  = 2'd2
    } state_t;

    localparam logic [3:0] LP_MAX = 4'(MAX_WAIT);

    state_t                r_state;
    logic [3:0]            r_starve;
    logic [15:0]           r_stall;

    logic                  w_force1;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_stall;

    // Grant decision; grants are masked while reset is low so nothing reaches the RAM.
    always_comb begin
        w_force1 = (r_starve == LP_MAX) && m1_req;
        w_gnt1   = reset && (w_force1 || (!m0_req && m1_req));
        w_gnt0   = reset && m0_req && !w_force1;
        w_stall  = (m0_req && !w_gnt0) || (m1_req && !w_gnt1);
    end

    // Route the winning requester onto the RAM port; zeros when idle.
    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        if (w_gnt0) begin
            w_we    = m0_we;
            w_addr  = m0_addr;
            w_wdata = m0_wdata;
        end else if (w_gnt1) begin
            w_we    = m1_we;
            w_addr  = m1_addr;
            w_wdata = m1_wdata;
        end
    end

    assign m0_gnt           = w_gnt0;
    assign m1_gnt           = w_gnt1;
    assign ram_read_enable  = (w_gnt0 || w_gnt1) && !w_we;
    assign ram_write_enable = (w_gnt0 || w_gnt1) && w_we;
    assign ram_address      = w_addr;
    assign ram_write_data   = w_wdata;

    assign m0_rvalid   = (r_state == S_RD0);
    assign m1_rvalid   = (r_state == S_RD1);
    assign m0_rdata    = m0_rvalid ? ram_read_data : '0;
    assign m1_rdata    = m1_rvalid ? ram_read_data : '0;
    assign stall_count = r_stall;

    // Read-return FSM: remember who owns the read data arriving next cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            if (w_gnt0 && !m0_we) begin
                r_state <= S_RD0;
            end else if (w_gnt1 && !m1_we) begin
                r_state <= S_RD1;
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

    // Starvation counter for requester 1, saturating at MAX_WAIT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_starve <= 4'd0;
        end else if (m1_req && !w_gnt1) begin
            if (r_starve != LP_MAX) begin
                r_starve <= r_starve + 4'd1;
            end
        end else begin
            r_starve <= 4'd0;
        end
    end

    // Saturating count of cycles in which any request was refused.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall <= 16'd0;
        end else if (w_stall && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors with a read-data scoreboard.
// A RAM model sits on the ram_* port; the monitor pops expected read returns.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [15:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [15:0] m1_addr, m1_wdata, m1_rdata;
    logic        ram_read_enable, ram_write_enable;
    logic [15:0] ram_address, ram_write_data, ram_read_data;
    logic [15:0] stall_count;

    int vectors = 0;
    int miscompares = 0;
    logic [16:0] exp_q [$];
    logic [15:0] mem [0:65535];

    mem_arbiter #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(16),
        .MAX_WAIT(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .m0_req(m0_req),
        .m0_we(m0_we),
        .m0_addr(m0_addr),
        .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req),
        .m1_we(m1_we),
        .m1_addr(m1_addr),
        .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .ram_read_enable(ram_read_enable),
        .ram_write_enable(ram_write_enable),
        .ram_address(ram_address),
        .ram_write_data(ram_write_data),
        .ram_read_data(ram_read_data),
        .stall_count(stall_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        ram_read_data = 16'h0000;
    end

    // Single-port synchronous RAM model
    always @(posedge clock) begin
        if (ram_write_enable) mem[ram_address] <= ram_write_data;
        if (ram_read_enable) ram_read_data <= mem[ram_address];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops and compares whenever a read return is presented
    always @(negedge clock) begin
        logic [16:0] e;
        if (m0_rvalid && m1_rvalid) begin
            chk("rvalid_overlap", 64'({m0_rvalid, m1_rvalid}), 64'b01);
        end else if (m0_rvalid || m1_rvalid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", 64'({m1_rvalid, m0_rvalid}), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rdata", 64'({m1_rvalid, m1_rvalid ? m1_rdata : m0_rdata}), 64'(e));
                chk("idle_rdata", 64'(m1_rvalid ? m0_rdata : m1_rdata), 64'd0);
            end
        end
    end

    task automatic drive(input logic r0, input logic w0, input logic [15:0] a0,
                         input logic [15:0] d0, input logic r1, input logic w1,
                         input logic [15:0] a1, input logic [15:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic step(input string name,
                        input logic r0, input logic w0, input logic [15:0] a0,
                        input logic [15:0] d0, input logic r1, input logic w1,
                        input logic [15:0] a1, input logic [15:0] d1,
                        input logic eg0, input logic eg1,
                        input logic push, input logic [15:0] erd);
        logic        ere, ewe;
        logic [15:0] ea, ed;
        @(negedge clock);
        drive(r0, w0, a0, d0, r1, w1, a1, d1);
        #1;
        chk({name, "_gnt"}, 64'({m0_gnt, m1_gnt}), 64'({eg0, eg1}));
        ere = 1'b0; ewe = 1'b0; ea = 16'h0; ed = 16'h0;
        if (eg0) begin
            ere = ~w0; ewe = w0; ea = a0; ed = d0;
        end else if (eg1) begin
            ere = ~w1; ewe = w1; ea = a1; ed = d1;
        end
        chk({name, "_ram"}, {ram_read_enable, ram_write_enable, ram_address, ram_write_data},
            {ere, ewe, ea, ed});
        if (push && ere) exp_q.push_back({eg1, erd});
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

        // Reset holds every output low even with a request pending
        repeat (2) @(negedge clock);
        #1;
        chk("rst_ctl", 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid,
                            ram_read_enable, ram_write_enable}), 64'd0);
        chk("rst_data", {m0_rdata, m1_rdata, ram_address, ram_write_data}, 64'd0);
        chk("rst_stall", 64'(stall_count), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rel_gnt", 64'({m0_gnt, m1_gnt}), 64'b10);
        chk("rel_stall", 64'(stall_count), 64'd0);
        exp_q.push_back({1'b0, 16'h0000});

        // m0 write then read back
        step("m0_wr", 1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0);
        step("m0_rd", 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0, 1, 16'hBEEF);
        step("idle", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0);

        // Seed data for later reads, one writer at a time
        step("m0_wr1", 1, 1, 16'h0001, 16'h1111, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0);
        step("m1_wr2", 0, 0, 16'h0, 16'h0, 1, 1, 16'h0002, 16'h2222, 0, 1, 0, 16'h0);
        step("idle", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0);
        chk("stall_pre", 64'(stall_count), 64'd0);

        // Continuous contention: m0 x4 then m1, repeating
        for (int i = 0; i < 10; i++) begin
            logic g1;
            g1 = (i % 5 == 4);
            step("cont", 1, 0, 16'h0001, 16'h0, 1, 0, 16'h0002, 16'h0,
                 ~g1, g1, 1, g1 ? 16'h2222 : 16'h1111);
        end
        step("idle", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0);
        chk("stall_cont", 64'(stall_count), 64'd10);

        // Back-to-back reads to different requesters
        step("b2b0", 1, 0, 16'h0001, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0, 1, 16'h1111);
        step("b2b1", 0, 0, 16'h0, 16'h0, 1, 0, 16'h0002, 16'h0, 0, 1, 1, 16'h2222);
        step("idle", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0);
        chk("stall_b2b", 64'(stall_count), 64'd10);

        // Reset right after an m1 read grant: its rvalid must never appear
        step("fly1", 0, 0, 16'h0, 16'h0, 1, 0, 16'h0002, 16'h0, 0, 1, 0, 16'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        @(negedge clock);
        #1;
        chk("fly1_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'd0);
        chk("fly1_stall", 64'(stall_count), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Build up starvation, then reset with an m0 read in flight
        step("pre0", 1, 0, 16'h0001, 16'h0, 1, 0, 16'h0002, 16'h0, 1, 0, 1, 16'h1111);
        step("pre1", 1, 0, 16'h0001, 16'h0, 1, 0, 16'h0002, 16'h0, 1, 0, 1, 16'h1111);
        step("pre2", 1, 0, 16'h0001, 16'h0, 1, 0, 16'h0002, 16'h0, 1, 0, 0, 16'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        @(negedge clock);
        #1;
        chk("fly0_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Starvation counter must have been cleared by reset
        for (int i = 0; i < 5; i++) begin
            logic g1;
            g1 = (i == 4);
            step("post", 1, 0, 16'h0001, 16'h0, 1, 0, 16'h0002, 16'h0,
                 ~g1, g1, 1, g1 ? 16'h2222 : 16'h1111);
        end
        step("idle", 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0);
        chk("stall_post", 64'(stall_count), 64'd5);

        // Long contention with writes: stall_count saturates without wrapping
        @(negedge clock);
        drive(1, 1, 16'h0030, 16'h3333, 1, 1, 16'h0031, 16'h4444);
        repeat (70000) @(posedge clock);
        @(negedge clock);
        #1;
        chk("stall_sat", 64'(stall_count), 64'hFFFF);
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        chk("stall_hold", 64'(stall_count), 64'hFFFF);
        drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);

        repeat (3) @(negedge clock);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
